// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM encoding and FIFO depth.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_reader_fifo2.sv
// Two-entry synchronous FIFO; simultaneous push and pop are allowed when non-empty.
module ram_reader_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential RAM read initiator presenting words on a valid/ready stream with backpressure.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   count,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_we,
  output logic             ram_oe,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] rd_addr;
  logic [DEPTH:0]   remaining;
  logic [DEPTH:0]   out_left;
  logic             pending;
  logic [1:0]       fifo_cnt;
  logic             pop;
  logic             issue;
  logic [2:0]       credit;
  logic             accept;

  // A read may only be issued if the word it returns is sure to find a FIFO slot.
  assign pop    = m_valid && m_ready;
  assign credit = 3'(fifo_cnt) + 3'(pending) - 3'(pop);
  assign issue  = (state == RUN) && (remaining != '0) && (credit < 3'd2);
  assign accept = (state == IDLE) && start;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? FINISH : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (pop && (out_left == (DEPTH+1)'(1))) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      remaining <= '0;
      out_left  <= '0;
      pending   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= issue;
      if (accept) begin
        rd_addr   <= base_addr;
        remaining <= count;
        out_left  <= count;
      end else begin
        if (issue) begin
          rd_addr   <= rd_addr + DEPTH'(1);
          remaining <= remaining - (DEPTH+1)'(1);
        end
        if (pop) out_left <= out_left - (DEPTH+1)'(1);
      end
    end
  end

  // The RAM's dout is only meaningful the cycle after an issue, so it is captured then.
  ram_reader_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pending),
    .pop   (pop),
    .din   (ram_dout),
    .dout  (m_data),
    .count (fifo_cnt)
  );

  assign m_valid     = (fifo_cnt != 2'd0);
  assign m_last      = m_valid && (out_left == (DEPTH+1)'(1));
  assign ram_address = rd_addr;
  assign ram_oe      = issue;
  assign ram_din     = '0;
  assign ram_we      = 1'b0;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a behavioural RAM and a sequence reference model.
module tb_ram_stream_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 10;
  localparam int WORDS = 1 << DEPTH;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [DEPTH-1:0] base_addr = '0;
  logic [DEPTH:0]   count = '0;
  logic             busy, done, ram_we, ram_oe, m_valid, m_last;
  logic [DEPTH-1:0] ram_address;
  logic [WIDTH-1:0] ram_din, m_data;
  logic [WIDTH-1:0] ram_dout = '0;
  logic             m_ready = 1'b0;

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_oe      (ram_oe),
    .ram_dout    (ram_dout),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready)
  );

  always #5 clk = ~clk;

  // Single-port RAM: dout refreshes every clock whatever oe says.
  logic [WIDTH-1:0] mem [WORDS];
  always @(posedge clk) begin
    ram_dout <= mem[ram_address];
    if (ram_we === 1'b1) mem[ram_address] <= ram_din;
  end

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] got_data [$];
  bit               got_last [$];
  logic [DEPTH-1:0] got_addr [$];
  int done_cnt, busy_cycles, first_valid, last_pop_c, done_c;
  int credit_viol, stable_viol, we_viol, timed_out;
  logic post_busy, post_done, ab_valid, ab_busy, ab_oe;

  // Runs one job, recording what the stream delivered plus protocol violations.
  task automatic run_job(input int base, input int cnt, input int mode,
                         input int abort_after, input int restart_base);
    int c, issued, popped, budget;
    bit p, prev_stall, prev_last;
    logic [WIDTH-1:0] prev_data;
    got_data.delete(); got_last.delete(); got_addr.delete();
    done_cnt = 0; busy_cycles = 0; first_valid = -1; last_pop_c = -1; done_c = -1;
    credit_viol = 0; stable_viol = 0; we_viol = 0; timed_out = 0;
    post_busy = 1'bx; post_done = 1'bx;
    issued = 0; popped = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    budget = 4 * cnt + 20;
    @(negedge clk);
    base_addr = DEPTH'(base);
    count = (DEPTH+1)'(cnt);
    start = 1'b1;
    c = -1;
    forever begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (abort_after > 0 && popped >= abort_after) begin
        reset = 1'b0;
        #1;
        ab_valid = m_valid; ab_busy = busy; ab_oe = ram_oe;
        @(negedge clk);
        reset = 1'b1;
        break;
      end
      if (restart_base >= 0 && c == 3) begin
        start = 1'b1;
        base_addr = DEPTH'(restart_base);
        count = (DEPTH+1)'(5);
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      p = m_valid && m_ready;
      if (busy === 1'b1) busy_cycles++;
      if (ram_we !== 1'b0 || ram_din !== '0) we_viol++;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        stable_viol++;
      if (ram_oe === 1'b1) begin
        if (issued - popped - int'(p) >= 2) credit_viol++;
        got_addr.push_back(ram_address);
        issued++;
      end
      if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (p) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        popped++;
        last_pop_c = c;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (done === 1'b1) begin
        done_cnt++;
        done_c = c;
        @(negedge clk);
        #1;
        post_busy = busy;
        post_done = done;
        break;
      end
      if (c > budget) begin
        timed_out = 1;
        break;
      end
    end
    start = 1'b0;
    m_ready = 1'b0;
  endtask

  // Counts disagreements between the recorded job and the expected word/address sequence.
  function automatic int words_off(input int base, input int cnt);
    int bad = 0;
    for (int k = 0; k < cnt; k++) begin
      int a;
      a = (base + k) % WORDS;
      if (k >= got_data.size() || got_data[k] !== mem[a] || got_last[k] !== (k == cnt - 1)) bad++;
      if (k >= got_addr.size() || got_addr[k] !== DEPTH'(a)) bad++;
    end
    if (got_data.size() > cnt || got_addr.size() > cnt) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (ram_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b required 0", ram_oe); end
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_stream: valid=%b last=%b required 0/0", m_valid, m_last); end
    checks++; if (ram_address !== '0 || m_data !== '0) begin errors++; $display("FAIL reset_regs: addr=%0d data=%0h required 0/0", ram_address, m_data); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int bad;
    run_job(0, 4, 0, 0, -1);
    bad = words_off(0, 4);
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_words: bad=%0d required 0", bad); end
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL basic_latency: got %0d required 2", first_valid); end
    checks++; if (done_cnt !== 1 || done_c !== last_pop_c + 1) begin errors++; $display("FAIL basic_done: count=%0d at %0d required 1 at %0d", done_cnt, done_c, last_pop_c + 1); end
    checks++; if (busy_cycles !== 7) begin errors++; $display("FAIL basic_busy: got %0d required 7", busy_cycles); end
    checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b done=%b required 0/0", post_busy, post_done); end
    checks++; if (we_viol !== 0 || timed_out !== 0) begin errors++; $display("FAIL basic_we: we=%0d timeout=%0d required 0/0", we_viol, timed_out); end
  endtask

  task automatic test_backpressure();
    int bad;
    run_job(8, 6, 1, 0, -1);
    bad = words_off(8, 6);
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_words: bad=%0d required 0", bad); end
    checks++; if (stable_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d required 0", stable_viol); end
    checks++; if (credit_viol !== 0) begin errors++; $display("FAIL bp_credit: got %0d required 0", credit_viol); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_random_ready();
    for (int n = 0; n < 4; n++) begin
      int base, cnt, bad;
      base = $urandom_range(0, WORDS - 1);
      cnt = $urandom_range(1, 40);
      run_job(base, cnt, 2, 0, -1);
      bad = words_off(base, cnt);
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand_words: job %0d bad=%0d required 0", n, bad); end
      checks++; if (stable_viol !== 0 || credit_viol !== 0) begin errors++; $display("FAIL rand_proto: stable=%0d credit=%0d required 0/0", stable_viol, credit_viol); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand_done: got %0d required 1", done_cnt); end
    end
  endtask

  task automatic test_wrap();
    int bad;
    run_job(1022, 4, 0, 0, -1);
    bad = words_off(1022, 4);
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_words: bad=%0d required 0", bad); end
  endtask

  task automatic test_zero_full();
    int bad, base;
    run_job(5, 0, 0, 0, -1);
    checks++; if (first_valid !== -1) begin errors++; $display("FAIL zero_valid: first at %0d required never", first_valid); end
    checks++; if (done_cnt !== 1 || busy_cycles !== 1) begin errors++; $display("FAIL zero_done: done=%0d busy=%0d required 1/1", done_cnt, busy_cycles); end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL zero_idle: busy=%b required 0", post_busy); end
    base = $urandom_range(0, WORDS - 1);
    run_job(base, WORDS, 0, 0, -1);
    bad = words_off(base, WORDS);
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_words: bad=%0d required 0", bad); end
    checks++; if (done_cnt !== 1 || busy_cycles !== WORDS + 3) begin errors++; $display("FAIL full_done: done=%0d busy=%0d required 1/%0d", done_cnt, busy_cycles, WORDS + 3); end
  endtask

  task automatic test_start_busy();
    int bad;
    run_job(20, 8, 0, 0, 100);
    bad = words_off(20, 8);
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_start_words: bad=%0d required 0", bad); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int bad;
    run_job(200, 8, 0, 3, -1);
    checks++; if (ab_valid !== 1'b0 || ab_busy !== 1'b0 || ab_oe !== 1'b0) begin errors++; $display("FAIL abort_outputs: valid=%b busy=%b oe=%b required 0/0/0", ab_valid, ab_busy, ab_oe); end
    checks++; if (done_cnt !== 0 || got_data.size() !== 3) begin errors++; $display("FAIL abort_partial: done=%0d words=%0d required 0/3", done_cnt, got_data.size()); end
    run_job(50, 2, 0, 0, -1);
    bad = words_off(50, 2);
    checks++; if (bad !== 0 || done_cnt !== 1) begin errors++; $display("FAIL abort_recover: bad=%0d done=%0d required 0/1", bad, done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = WIDTH'(i);
    test_reset();
    test_basic();
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    test_backpressure();
    test_random_ready();
    test_wrap();
    test_zero_full();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
